// File: rtl/sp_pkg.sv
// Shared single-port core package: register file geometry and
// the writeback request bundle carried into the write scheduler.
package sp_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int NUM_REG        = 8;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]           data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Writeback request bus: one valid/ready/payload lane per
// requester, shared by the execute/memory units.
interface rf_write_scheduler_if #(
  parameter int NUM_REQ = 2
);
  import sp_pkg::*;

  logic    [NUM_REQ-1:0] req_valid;
  logic    [NUM_REQ-1:0] req_ready;
  wb_req_t [NUM_REQ-1:0] req;

  modport master (
    output req_valid,
    output req,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req,
    output req_ready
  );

endinterface

// File: rtl/rf_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching
// upward from a registered pointer, advanced past each winner.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin : search
    logic          found;
    logic [IW-1:0] j;
    int            s;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = '0;
    s       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      j = IW'(s);
      if (!found && valid_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (idx_o == IW'(NUM_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register file write-port scheduler: RR arbitration of writeback
// requesters, registered write stage and per-register busy scoreboard.
module rf_write_scheduler
  import sp_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  rf_write_scheduler_if.slave       wb,
  input  logic                      reserve_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] reserve_addr_i,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [XLEN-1:0]           rd_data_o,
  output logic                      rd_en_o,
  output logic [NUM_REG-1:0]        busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] win_idx;
  logic          xfer;
  wb_req_t       win_req;

  logic                      en_q, en_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]           data_q, data_d;
  logic [NUM_REG-1:0]        busy_q, busy_d;

  // The write port never stalls: any valid means a transfer.
  assign xfer    = |wb.req_valid;
  assign win_req = wb.req[win_idx];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .valid_i   (wb.req_valid),
    .advance_i (xfer),
    .grant_o   (wb.req_ready),
    .idx_o     (win_idx)
  );

  always_comb begin
    en_d   = xfer && (win_req.addr != '0);
    addr_d = addr_q;
    data_d = data_q;
    if (xfer) begin
      addr_d = win_req.addr;
      data_d = win_req.data;
    end
  end

  // Clear on commit, then set on reserve so reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (en_q) busy_d[addr_q] = 1'b0;
    if (reserve_valid_i) busy_d[reserve_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign rd_en_o   = en_q;
  assign rd_addr_o = addr_q;
  assign rd_data_o = data_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: directed cases followed by
// random traffic against a queue-based RR / scoreboard / regfile model.
module tb_rf_write_scheduler;
  import sp_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        arst_ni;
  logic        rsv_v;
  logic [2:0]  rsv_a;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_en;
  logic [7:0]  busy;

  rf_write_scheduler_if #(.NUM_REQ(N)) intf ();

  rf_write_scheduler #(.NUM_REQ(N)) dut (
    .clk_i           (clk),
    .arst_ni         (arst_ni),
    .wb              (intf.slave),
    .reserve_valid_i (rsv_v),
    .reserve_addr_i  (rsv_a),
    .rd_addr_o       (rd_addr),
    .rd_data_o       (rd_data),
    .rd_en_o         (rd_en),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [7:0]  busy;
  } exp_t;

  exp_t        eq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          in_reset = 1'b1;
  bit          done = 1'b0;

  int          m_ptr;
  logic [7:0]  m_busy;
  bit          m_pend;
  logic [2:0]  m_paddr;
  logic [31:0] m_pdata;
  logic [31:0] rf_m [8];
  logic [31:0] rf_d [8];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_pend = 1'b0;
  endtask

  // One cycle: drive at negedge+1, check ready, queue expected outcome.
  task automatic step(input logic [1:0]  v,
                      input logic [2:0]  a0,
                      input logic [31:0] d0,
                      input logic [2:0]  a1,
                      input logic [31:0] d1,
                      input logic        rv,
                      input logic [2:0]  ra,
                      output int         win);
    logic [2:0]  wa [N];
    logic [31:0] wd [N];
    logic [1:0]  er;
    exp_t        e;
    wa[0] = a0; wd[0] = d0;
    wa[1] = a1; wd[1] = d1;
    intf.req_valid = v;
    intf.req[0] = '{addr: a0, data: d0};
    intf.req[1] = '{addr: a1, data: d1};
    rsv_v = rv;
    rsv_a = ra;
    #1;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && v[(m_ptr + k) % N])
        win = (m_ptr + k) % N;
    er = (win < 0) ? 2'b00 : 2'(1 << win);
    check("req_ready", 32'(intf.req_ready), 32'(er));
    if (m_pend) begin
      rf_m[m_paddr] = m_pdata;
      m_busy[m_paddr] = 1'b0;
    end
    if (rv && ra != 0) m_busy[ra] = 1'b1;
    m_busy[0] = 1'b0;
    e.en   = (win >= 0) && (wa[win < 0 ? 0 : win] != 0);
    e.addr = wa[win < 0 ? 0 : win];
    e.data = wd[win < 0 ? 0 : win];
    e.busy = m_busy;
    eq.push_back(e);
    m_pend  = e.en;
    m_paddr = e.addr;
    m_pdata = e.data;
    if (win >= 0) m_ptr = (win + 1) % N;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < n; i++)
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, w);
  endtask

  always @(posedge clk)
    if (arst_ni && rd_en) rf_d[rd_addr] <= rd_data;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!in_reset && !done) begin
        if (eq.size() == 0) begin
          check("queue_underflow", 1, 0);
        end else begin
          e = eq.pop_front();
          check("rd_en", 32'(rd_en), 32'(e.en));
          if (e.en) begin
            check("rd_addr", 32'(rd_addr), 32'(e.addr));
            check("rd_data", rd_data, e.data);
          end
          check("busy", 32'(busy), 32'(e.busy));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         w;
    logic [1:0] pv;
    logic [2:0] pa [N];
    logic [31:0] pd [N];
    for (int r = 0; r < 8; r++) begin
      rf_m[r] = '0;
      rf_d[r] = '0;
    end
    arst_ni = 1'b0;
    intf.req_valid = '0;
    intf.req[0] = '0;
    intf.req[1] = '0;
    rsv_v = 1'b0;
    rsv_a = '0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    arst_ni  = 1'b1;
    in_reset = 1'b0;

    step(2'b01, 3, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, w);
    idle(2);

    for (int i = 0; i < 6; i++)
      step(2'b11, 1, 32'h11, 2, 32'h22, 1'b0, 0, w);
    idle(1);

    step(2'b01, 0, 32'h1234, 0, 0, 1'b0, 0, w);
    idle(1);

    step(2'b00, 0, 0, 0, 0, 1'b1, 5, w);
    step(2'b01, 5, 32'h55, 0, 0, 1'b0, 0, w);
    idle(1);
    step(2'b00, 0, 0, 0, 0, 1'b1, 5, w);
    step(2'b01, 5, 32'h66, 0, 0, 1'b0, 0, w);
    step(2'b00, 0, 0, 0, 0, 1'b1, 5, w);
    step(2'b00, 0, 0, 0, 0, 1'b1, 0, w);
    step(2'b10, 0, 0, 5, 32'h77, 1'b0, 0, w);
    idle(1);

    step(2'b01, 4, 32'h44, 0, 0, 1'b1, 6, w);
    in_reset = 1'b1;
    arst_ni  = 1'b0;
    #1;
    check("midrst_rd_en", 32'(rd_en), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    arst_ni = 1'b1;
    model_reset();
    in_reset = 1'b0;
    step(2'b11, 1, 32'hA1, 2, 32'hB2, 1'b0, 0, w);
    check("post_rst_winner", 32'(w), 0);
    step(2'b10, 1, 32'hA1, 2, 32'hB2, 1'b0, 0, w);
    idle(1);

    pv = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pd[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i] = 1'b1;
          pa[i] = 3'($urandom_range(0, 7));
          pd[i] = $urandom;
        end
      step(pv, pa[0], pd[0], pa[1], pd[1],
           1'($urandom_range(0, 9) < 3),
           3'($urandom_range(0, 7)), w);
      if (w >= 0) pv[w] = 1'b0;
    end
    idle(3);
    done = 1'b1;
    check("queue_drained", 32'(eq.size()), 0);
    for (int r = 1; r < 8; r++)
      check($sformatf("regfile_x%0d", r), rf_d[r], rf_m[r]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
